mem_bus_arbiter: RTL and testbench

// - Shares the core's single AHB-Lite master port between the instruction-cache refill path and the data load/store path.
// - Arbitrates between the two, sequences non-pipelined single transfers (address phase, then data phase) and returns data/error to the winner.
// - Sits between ICACHE/LSU and the system AHB interconnect.

---
 rtl/svarog_ahb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/svarog_ahb_pkg.sv
// rtl/svarog_ahb_pkg.sv - shared AHB-Lite encodings and arbiter state types
package svarog_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IC,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - icache/data winner select with starvation counter
module mem_arb_pick
    import svarog_ahb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic arb_en_i,
    input  logic ic_req_i,
    input  logic d_req_i,
    output logic ic_win_o,
    output logic d_win_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q;
    logic          starve_hit;

    assign starve_hit = (starve_cnt_q == LIMIT);

    // Data normally wins; icache only wins when it has been starved long enough.
    assign ic_win_o = arb_en_i && ic_req_i && (!d_req_i || starve_hit);
    assign d_win_o  = arb_en_i && d_req_i && !ic_win_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            starve_cnt_q <= '0;
        end else if (ic_win_o) begin
            starve_cnt_q <= '0;
        end else if (d_win_o && ic_req_i && !starve_hit) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one AHB-Lite master port between icache refill and LSU
module mem_bus_arbiter
    import svarog_ahb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ic_req_i,
    input  logic [DATA_WIDTH-1:0] ic_addr_i,
    output logic                  ic_gnt_o,
    output logic                  ic_rvalid_o,
    output logic [DATA_WIDTH-1:0] ic_rdata_o,
    output logic                  ic_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [1:0]            d_size_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,
    output logic [DATA_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    arb_state_t            state_q, state_d;
    owner_t                owner_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic                  we_q;
    logic [2:0]            size_q;
    logic                  arb_en, ic_win, d_win, xfer_done;

    // Gating with reset keeps grants silent while reset is held with requests pending.
    assign arb_en    = (state_q == ARB_IDLE) && reset_i;
    assign xfer_done = (state_q == ARB_DATA) && hready_i;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .arb_en_i (arb_en),
        .ic_req_i (ic_req_i),
        .d_req_i  (d_req_i),
        .ic_win_o (ic_win),
        .d_win_o  (d_win)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        htrans_o = HTRANS_IDLE;
        hwdata_o = '0;
        ic_gnt_o = ic_win;
        d_gnt_o  = d_win;
        haddr_o  = addr_q;
        hwrite_o = we_q;
        hsize_o  = size_q;
        case (state_q)
            ARB_IDLE: if (ic_win || d_win) state_d = ARB_ADDR;
            ARB_ADDR: begin
                htrans_o = HTRANS_NONSEQ;
                if (hready_i) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                hwdata_o = wdata_q;
                if (hready_i) state_d = ARB_IDLE;
            end
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            size_q      <= 3'b000;
            ic_rvalid_o <= 1'b0;
            ic_rdata_o  <= '0;
            ic_err_o    <= 1'b0;
            d_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
            d_err_o     <= 1'b0;
        end else begin
            ic_rvalid_o <= xfer_done && (owner_q == OWN_IC);
            d_rvalid_o  <= xfer_done && (owner_q == OWN_D);
            if (ic_win) begin
                owner_q <= OWN_IC;
                addr_q  <= ic_addr_i;
                wdata_q <= '0;
                we_q    <= 1'b0;
                size_q  <= HSIZE_WORD;
            end else if (d_win) begin
                owner_q <= OWN_D;
                addr_q  <= d_addr_i;
                wdata_q <= d_wdata_i;
                we_q    <= d_we_i;
                size_q  <= {1'b0, d_size_i};
            end else if (xfer_done) begin
                owner_q <= OWN_NONE;
            end
            if (xfer_done && owner_q == OWN_IC) begin
                ic_rdata_o <= hrdata_i;
                ic_err_o   <= hresp_i;
            end
            if (xfer_done && owner_q == OWN_D) begin
                d_rdata_o <= hrdata_i;
                d_err_o   <= hresp_i;
            end
        end
    end

    ic_req_held: assert property (@(posedge clk_i) disable iff (!reset_i)
        (ic_req_i && !ic_gnt_o) |=> ic_req_i);
    d_req_held: assert property (@(posedge clk_i) disable iff (!reset_i)
        (d_req_i && !d_gnt_o) |=> d_req_i);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ic_req_i;
    logic [31:0] ic_addr_i;
    logic        ic_gnt_o, ic_rvalid_o, ic_err_o;
    logic [31:0] ic_rdata_o;
    logic        d_req_i, d_we_i;
    logic [1:0]  d_size_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic [31:0] haddr_o, hwdata_o, hrdata_i;
    logic [1:0]  htrans_o;
    logic        hwrite_o, hready_i, hresp_i;
    logic [2:0]  hsize_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    mem_bus_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
        .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_err_o(ic_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
        .hwdata_o(hwdata_o), .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        cyc(); ic_req_i = 1'b1; d_req_i = 1'b1; mid();
        n_cmp++; if ({ic_gnt_o, d_gnt_o} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", {ic_gnt_o, d_gnt_o}); end
        n_cmp++; if (htrans_o !== 2'b00) begin n_bad++; $display("FAIL reset_htrans: got %b want 00", htrans_o); end
        n_cmp++; if ({ic_rvalid_o, d_rvalid_o, hwrite_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {ic_rvalid_o, d_rvalid_o, hwrite_o}); end
        n_cmp++; if ({haddr_o, hwdata_o} !== 64'h0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {haddr_o, hwdata_o}); end
        cyc(); ic_req_i = 1'b0; d_req_i = 1'b0; reset_i = 1'b1; mid();
    endtask

    task automatic test_ic_read();
        cyc(); ic_req_i = 1'b1; ic_addr_i = 32'h0000_0040; hready_i = 1'b1; hrdata_i = 32'hDEAD_BEEF; mid();
        n_cmp++; if ({ic_gnt_o, d_gnt_o} !== 2'b10) begin n_bad++; $display("FAIL ic_gnt0: got %b want 10", {ic_gnt_o, d_gnt_o}); end
        cyc(); ic_req_i = 1'b0; ic_addr_i = 32'h0; mid();
        n_cmp++; if (htrans_o !== 2'b10 || haddr_o !== 32'h40) begin n_bad++; $display("FAIL ic_nonseq1: got %b/%h want 10/00000040", htrans_o, haddr_o); end
        n_cmp++; if (hwrite_o !== 1'b0 || hsize_o !== 3'b010) begin n_bad++; $display("FAIL ic_ctrl1: got %b/%b want 0/010", hwrite_o, hsize_o); end
        cyc(); mid();
        n_cmp++; if (htrans_o !== 2'b00 || ic_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL ic_data2: got %b/%b want 00/0", htrans_o, ic_rvalid_o); end
        cyc(); hrdata_i = 32'h0; mid();
        n_cmp++; if (ic_rvalid_o !== 1'b1 || d_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL ic_rvalid3: got %b/%b want 1/0", ic_rvalid_o, d_rvalid_o); end
        n_cmp++; if (ic_rdata_o !== 32'hDEAD_BEEF || ic_err_o !== 1'b0) begin n_bad++; $display("FAIL ic_rdata3: got %h/%b want deadbeef/0", ic_rdata_o, ic_err_o); end
        cyc(); mid();
        n_cmp++; if (ic_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL ic_rvalid4: got %b want 0", ic_rvalid_o); end
    endtask

    task automatic test_d_write_wait();
        cyc(); d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = 2'd0; d_addr_i = 32'h2000_0004; d_wdata_i = 32'hA5; mid();
        n_cmp++; if ({ic_gnt_o, d_gnt_o} !== 2'b01) begin n_bad++; $display("FAIL dw_gnt0: got %b want 01", {ic_gnt_o, d_gnt_o}); end
        cyc(); d_req_i = 1'b0; d_wdata_i = 32'h0; d_we_i = 1'b0; mid();
        n_cmp++; if (htrans_o !== 2'b10 || haddr_o !== 32'h2000_0004) begin n_bad++; $display("FAIL dw_addr1: got %b/%h want 10/20000004", htrans_o, haddr_o); end
        n_cmp++; if (hwrite_o !== 1'b1 || hsize_o !== 3'b000) begin n_bad++; $display("FAIL dw_ctrl1: got %b/%b want 1/000", hwrite_o, hsize_o); end
        for (int c = 2; c <= 4; c++) begin
            cyc(); hready_i = (c == 4); mid();
            n_cmp++; if (hwdata_o !== 32'hA5 || htrans_o !== 2'b00 || d_rvalid_o !== 1'b0) begin
                n_bad++; $display("FAIL dw_data%0d: got %h/%b/%b want 000000a5/00/0", c, hwdata_o, htrans_o, d_rvalid_o);
            end
        end
        cyc(); mid();
        n_cmp++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b0 || ic_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL dw_rvalid5: got %b/%b/%b want 1/0/0", d_rvalid_o, d_err_o, ic_rvalid_o); end
    endtask

    task automatic test_starve();
        bit [10:0] exp_ic = 11'b010_0001_0000;
        int  n = 0;
        bit  drop_ic = 1'b0;
        cyc(); ic_addr_i = 32'h100; d_addr_i = 32'h2000_0100; d_we_i = 1'b0; d_size_i = 2'd2;
        hrdata_i = 32'h1111_2222; hready_i = 1'b1; ic_req_i = 1'b1; d_req_i = 1'b1;
        for (int c = 0; c < 60 && n < 11; c++) begin
            if (c > 0) begin cyc(); if (drop_ic) ic_req_i = 1'b0; end
            mid();
            if (ic_gnt_o || d_gnt_o) begin
                n_cmp++; if (ic_gnt_o !== exp_ic[n] || (ic_gnt_o && d_gnt_o)) begin
                    n_bad++; $display("FAIL starve_order[%0d]: got ic=%b d=%b want ic=%b", n, ic_gnt_o, d_gnt_o, exp_ic[n]);
                end
                n++;
                if (n == 10) drop_ic = 1'b1;
            end
        end
        cyc(); ic_req_i = 1'b0; d_req_i = 1'b0; mid();
        n_cmp++; if (n != 11) begin n_bad++; $display("FAIL starve_timeout: got %0d grants want 11", n); end
        cyc(); cyc(); mid();
        n_cmp++; if (d_rvalid_o !== 1'b1 || ic_rdata_o !== 32'h1111_2222) begin n_bad++; $display("FAIL starve_last: got %b/%h want 1/11112222", d_rvalid_o, ic_rdata_o); end
    endtask

    task automatic test_d_error();
        cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_addr_i = 32'h3000_0000; hready_i = 1'b1; hresp_i = 1'b0; mid();
        n_cmp++; if (d_gnt_o !== 1'b1) begin n_bad++; $display("FAIL de_gnt: got %b want 1", d_gnt_o); end
        cyc(); d_req_i = 1'b0; mid();
        cyc(); hready_i = 1'b0; hresp_i = 1'b1; hrdata_i = 32'hBAD0_BAD0; mid();
        n_cmp++; if (d_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL de_err1: got %b want 0", d_rvalid_o); end
        cyc(); hready_i = 1'b1; mid();
        n_cmp++; if (d_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL de_err2: got %b want 0", d_rvalid_o); end
        cyc(); hresp_i = 1'b0; hrdata_i = 32'h0; mid();
        n_cmp++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b1 || d_rdata_o !== 32'hBAD0_BAD0) begin n_bad++; $display("FAIL de_done: got %b/%b/%h want 1/1/bad0bad0", d_rvalid_o, d_err_o, d_rdata_o); end
        n_cmp++; if (ic_rvalid_o !== 1'b0 || ic_err_o !== 1'b0 || ic_rdata_o !== 32'h1111_2222) begin n_bad++; $display("FAIL de_ic_quiet: got %b/%b/%h want 0/0/11112222", ic_rvalid_o, ic_err_o, ic_rdata_o); end
        cyc(); mid();
        n_cmp++; if (d_rvalid_o !== 1'b0 || d_err_o !== 1'b1) begin n_bad++; $display("FAIL de_hold: got %b/%b want 0/1", d_rvalid_o, d_err_o); end
    endtask

    task automatic test_reset_mid();
        cyc(); ic_req_i = 1'b1; ic_addr_i = 32'h80; hready_i = 1'b1; mid();
        n_cmp++; if (ic_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rm_gnt0: got %b want 1", ic_gnt_o); end
        cyc(); ic_req_i = 1'b0; mid();
        cyc(); hready_i = 1'b0; reset_i = 1'b0; ic_req_i = 1'b1; mid();
        n_cmp++; if (htrans_o !== 2'b00 || ic_gnt_o !== 1'b0 || haddr_o !== 32'h0) begin n_bad++; $display("FAIL rm_in_reset: got %b/%b/%h want 00/0/0", htrans_o, ic_gnt_o, haddr_o); end
        cyc(); hready_i = 1'b1; hrdata_i = 32'hCAFE_F00D; mid();
        n_cmp++; if (ic_rvalid_o !== 1'b0 || ic_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rm_no_rvalid: got %b/%b want 0/0", ic_rvalid_o, ic_gnt_o); end
        cyc(); reset_i = 1'b1; mid();
        n_cmp++; if (ic_gnt_o !== 1'b1 || ic_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rm_regrant: got %b/%b want 1/0", ic_gnt_o, ic_rvalid_o); end
        cyc(); ic_req_i = 1'b0; mid();
        n_cmp++; if (htrans_o !== 2'b10 || haddr_o !== 32'h80) begin n_bad++; $display("FAIL rm_addr: got %b/%h want 10/00000080", htrans_o, haddr_o); end
        cyc(); cyc(); mid();
        n_cmp++; if (ic_rvalid_o !== 1'b1 || ic_rdata_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rm_done: got %b/%h want 1/cafef00d", ic_rvalid_o, ic_rdata_o); end
    endtask

    task automatic test_addr_wait();
        int gcnt = 0;
        cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd1; d_addr_i = 32'h4000_0010; hready_i = 1'b0; hrdata_i = 32'h5A5A; mid();
        gcnt += int'(d_gnt_o);
        for (int c = 1; c <= 4; c++) begin
            cyc(); hready_i = (c == 4); mid();
            gcnt += int'(d_gnt_o);
            n_cmp++; if (htrans_o !== 2'b10 || haddr_o !== 32'h4000_0010 || hwrite_o !== 1'b0 || hsize_o !== 3'b001) begin
                n_bad++; $display("FAIL aw_stable%0d: got %b/%h/%b/%b want 10/40000010/0/001", c, htrans_o, haddr_o, hwrite_o, hsize_o);
            end
        end
        cyc(); mid();
        gcnt += int'(d_gnt_o);
        n_cmp++; if (gcnt != 1) begin n_bad++; $display("FAIL aw_one_gnt: got %0d want 1", gcnt); end
        cyc(); mid();
        n_cmp++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h5A5A || d_gnt_o !== 1'b1) begin n_bad++; $display("FAIL aw_done: got %b/%h/%b want 1/00005a5a/1", d_rvalid_o, d_rdata_o, d_gnt_o); end
        cyc(); d_req_i = 1'b0; mid();
        cyc(); cyc(); mid();
        n_cmp++; if (d_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL aw_second: got %b want 1", d_rvalid_o); end
    endtask

    initial begin
        reset_i = 1'b0; ic_req_i = 1'b0; ic_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
        d_size_i = '0; d_addr_i = '0; d_wdata_i = '0; hrdata_i = '0; hready_i = 1'b1; hresp_i = 1'b0;
        test_reset();
        test_ic_read();
        test_d_write_wait();
        test_starve();
        test_d_error();
        test_reset_mid();
        test_addr_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
